// File: rtl/divisor_restoring.sv
// Unsigned restoring shift-and-subtract divider: one quotient bit per clock.
// Quotient, remainder and flags are held in registers until the next operation completes.
module divisor_restoring #(
    parameter int tamano = 8
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic [tamano-1:0] A,
    input  logic [tamano-1:0] B,
    output logic [tamano-1:0] Q,
    output logic [tamano-1:0] R,
    output logic              END_DIV,
    output logic              DIV_BY_ZERO,
    output logic              BUSY
);

    localparam int CW = $clog2(tamano + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [tamano:0]   p_r;
    logic [tamano-1:0] d_r;
    logic [tamano-1:0] m_r;
    logic [CW-1:0]     cnt_r;

    logic [tamano+1:0] shifted_s;
    logic [tamano:0]   trial_s;
    logic              borrow_s;
    logic [tamano:0]   p_next_s;
    logic [tamano-1:0] d_next_s;
    logic              last_s;
    logic              start_ok_s;

    // Shift {P,D} left one place and trial-subtract the divisor from the partial remainder.
    always_comb begin
        shifted_s  = {p_r, d_r[tamano-1]};
        borrow_s   = (shifted_s < {2'b00, m_r});
        trial_s    = shifted_s[tamano:0] - {1'b0, m_r};
        p_next_s   = borrow_s ? shifted_s[tamano:0] : trial_s;
        d_next_s   = {d_r[tamano-2:0], ~borrow_s};
        last_s     = (cnt_r == CW'(tamano - 1));
        start_ok_s = (B != {tamano{1'b0}});
    end

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
                    state_s = start_ok_s ? ITER : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            ITER: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ITER;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath registers and held results.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            p_r         <= {(tamano + 1){1'b0}};
            d_r         <= {tamano{1'b0}};
            m_r         <= {tamano{1'b0}};
            cnt_r       <= {CW{1'b0}};
            Q           <= {tamano{1'b0}};
            R           <= {tamano{1'b0}};
            DIV_BY_ZERO <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (START && start_ok_s) begin
                        m_r   <= B;
                        d_r   <= A;
                        p_r   <= {(tamano + 1){1'b0}};
                        cnt_r <= {CW{1'b0}};
                    end else if (START) begin
                        Q           <= {tamano{1'b1}};
                        R           <= A;
                        DIV_BY_ZERO <= 1'b1;
                    end
                end
                ITER: begin
                    p_r   <= p_next_s;
                    d_r   <= d_next_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        Q           <= d_next_s;
                        R           <= p_next_s[tamano-1:0];
                        DIV_BY_ZERO <= 1'b0;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Status outputs registered from the next state so they line up with the state register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            END_DIV <= 1'b0;
            BUSY    <= 1'b0;
        end else begin
            END_DIV <= (state_s == DONE);
            BUSY    <= (state_s != IDLE);
        end
    end

endmodule

// File: tb/tb_divisor_restoring.sv
// Scoreboard bench for divisor_restoring: the stimulus side queues expected results,
// and a monitor checks each END_DIV pulse against the head of the queue.
module tb_divisor_restoring;

    localparam int W = 8;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] A = 8'd0;
    logic [W-1:0] B = 8'd0;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         END_DIV;
    logic         DIV_BY_ZERO;
    logic         BUSY;

    divisor_restoring #(.tamano(W)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .A(A), .B(B),
        .Q(Q), .R(R), .END_DIV(END_DIV), .DIV_BY_ZERO(DIV_BY_ZERO), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    int unsigned cyc = 0;
    always @(posedge CLOCK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int unsigned  endc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    bit          sweep = 1'b0;
    bit          have_last = 1'b0;
    int unsigned last_end = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(negedge CLOCK) begin
        if (RESET && END_DIV) begin
            if (sb.size() == 0) begin
                check("spurious_end_div", END_DIV, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", Q, mon_e.q);
                check("remainder", R, mon_e.r);
                check("div_by_zero", DIV_BY_ZERO, mon_e.dz);
                check("latency", cyc, mon_e.endc);
                if (sweep && have_last) check("spacing", cyc - last_end, 10);
                last_end  = cyc;
                have_last = 1'b1;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input bit hold);
        exp_t e;
        int   n;
        n = 0;
        @(negedge CLOCK);
        while (BUSY && n < 100) begin
            @(negedge CLOCK);
            n++;
        end
        if (BUSY) check("idle_timeout", BUSY, 1'b0);
        A = a;
        B = b;
        START = 1'b1;
        @(posedge CLOCK);
        #1;
        e.q = q;
        e.r = r;
        e.dz = dz;
        e.endc = (b != 8'd0) ? cyc + W : cyc;
        sb.push_back(e);
        if (!hold) START = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLOCK);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    int          bc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        repeat (2) @(negedge CLOCK);
        check("rst_q", Q, 0);
        check("rst_r", R, 0);
        check("rst_end_div", END_DIV, 0);
        check("rst_dbz", DIV_BY_ZERO, 0);
        check("rst_busy", BUSY, 0);
        RESET = 1'b1;

        // Basic operation with BUSY duration.
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        bc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK);
            if (BUSY) bc++;
            else break;
        end
        check("busy_cycles", bc, 9);
        drain();

        issue(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
        issue(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0);
        issue(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0);
        issue(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 1'b0);
        drain();
        repeat (3) @(negedge CLOCK);
        check("dbz_hold", DIV_BY_ZERO, 1'b1);
        check("q_hold", Q, 8'd255);
        issue(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
        drain();

        // START pulsed while busy, inputs changed after capture.
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        @(posedge CLOCK);
        @(posedge CLOCK);
        @(negedge CLOCK);
        START = 1'b1;
        A = 8'd1;
        B = 8'd1;
        @(posedge CLOCK);
        #1;
        START = 1'b0;
        A = 8'd50;
        B = 8'd3;
        drain();
        repeat (15) @(negedge CLOCK);

        // Asynchronous reset mid-operation.
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0);
        repeat (4) @(posedge CLOCK);
        #2;
        RESET = 1'b0;
        sb.delete();
        #1;
        check("abort_q", Q, 0);
        check("abort_r", R, 0);
        check("abort_end_div", END_DIV, 0);
        check("abort_busy", BUSY, 0);
        @(negedge CLOCK);
        RESET = 1'b1;
        issue(8'd77, 8'd10, 8'd7, 8'd7, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge CLOCK);

        // Back-to-back sweep with START held high.
        have_last = 1'b0;
        sweep = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            issue(ra, rb, ra / rb, ra % rb, 1'b0, 1'b1);
        end
        START = 1'b0;
        drain();
        sweep = 1'b0;
        repeat (15) @(negedge CLOCK);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
